// File: rtl/cache_repl_pkg.sv
// Shared helpers for cache replacement logic: log2, heap-indexed tree node
// navigation, and way vector types for the default 4-way configuration.
package cache_repl_pkg;

    localparam int CACHE_WAYS = 4;

    typedef logic [CACHE_WAYS-1:0] way_vec_t;   // one-hot way vector
    typedef logic [1:0]            way_idx_t;   // binary way index

    // Ceiling log2, usable in constant expressions
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Heap layout: node 0 is the root, children of n are 2n+1 / 2n+2
    function automatic int left_child(input int n);
        return 2 * n + 1;
    endfunction

    function automatic int right_child(input int n);
        return 2 * n + 2;
    endfunction

    function automatic int parent_node(input int n);
        return (n - 1) / 2;
    endfunction

endpackage

// File: rtl/plru_tree_walk.sv
// Combinational tree-PLRU victim walk. Leaves sit at heap nodes
// NUMBER_OF_WAYS-1 .. 2*NUMBER_OF_WAYS-2 (way i = node NUMBER_OF_WAYS-1+i).
// With PLRU_WAY_LOCK_EN, a node whose preferred subtree is fully locked is
// steered to its other child; if every way is locked no way is chosen.
module plru_tree_walk
    import cache_repl_pkg::*;
#(
    parameter int NUMBER_OF_WAYS = 4
) (
    input  logic [NUMBER_OF_WAYS-2:0] plru_bits,
`ifdef PLRU_WAY_LOCK_EN
    input  logic [NUMBER_OF_WAYS-1:0] lock_mask,
    output logic                      victim_none,
`endif
    output logic [NUMBER_OF_WAYS-1:0] victim_way
);

    localparam int NODES = NUMBER_OF_WAYS - 1;
    localparam int TREE  = 2 * NUMBER_OF_WAYS - 1;

    // Resolve each node's direction, then propagate a single path enable
    // from the root to exactly one leaf
    always_comb begin
        logic [NODES-1:0] dir;
        logic [TREE-1:0]  en;
`ifdef PLRU_WAY_LOCK_EN
        logic [TREE-1:0]  locked;
        locked = '0;
        for (int i = 0; i < NUMBER_OF_WAYS; i++) locked[NODES+i] = lock_mask[i];
        for (int n = NODES - 1; n >= 0; n--)
            locked[n] = locked[left_child(n)] & locked[right_child(n)];
`endif
        dir = plru_bits;
`ifdef PLRU_WAY_LOCK_EN
        for (int n = 0; n < NODES; n++) begin
            if (plru_bits[n] && locked[right_child(n)])
                dir[n] = 1'b0;
            else if (!plru_bits[n] && locked[left_child(n)])
                dir[n] = 1'b1;
        end
`endif
        en    = '0;
        en[0] = 1'b1;
        for (int n = 0; n < NODES; n++) begin
            en[left_child(n)]  = en[n] & ~dir[n];
            en[right_child(n)] = en[n] &  dir[n];
        end
        victim_way = en[TREE-1:NODES];
`ifdef PLRU_WAY_LOCK_EN
        victim_none = locked[0];
        if (locked[0]) victim_way = '0;
`endif
    end

endmodule

// File: rtl/plru_victim_select.sv
// Per-set victim selection: lowest empty way first, else tree-PLRU victim.
// PLRU state is updated on every one-hot hit/fill; a lookup in the same cycle
// as an access to the same set sees the updated bits. Response is registered,
// one cycle after the lookup.
// Optional feature macro: PLRU_WAY_LOCK_EN (adds lock_mask / victim_none).
module plru_victim_select
    import cache_repl_pkg::*;
#(
    parameter  int NUMBER_OF_WAYS = 4,
    parameter  int NUMBER_OF_SETS = 256,
    localparam int INDEX_BITS     = clog2(NUMBER_OF_SETS),
    localparam int WAY_BITS       = clog2(NUMBER_OF_WAYS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      lookup_valid,
    input  logic [INDEX_BITS-1:0]     lookup_set,
    input  logic [NUMBER_OF_WAYS-1:0] ways_in_use,
    input  logic                      access_valid,
    input  logic [INDEX_BITS-1:0]     access_set,
    input  logic [NUMBER_OF_WAYS-1:0] access_way,
`ifdef PLRU_WAY_LOCK_EN
    input  logic [NUMBER_OF_WAYS-1:0] lock_mask,
    output logic                      victim_none,
`endif
    output logic                      victim_valid,
    output logic [NUMBER_OF_WAYS-1:0] victim_way,
    output logic [WAY_BITS-1:0]       victim_index,
    output logic                      victim_empty,
    output logic                      access_error
);

    localparam int NODES = NUMBER_OF_WAYS - 1;
    localparam int TREE  = 2 * NUMBER_OF_WAYS - 1;

    logic [NODES-1:0]          plru_q [NUMBER_OF_SETS];
    logic [NODES-1:0]          plru_d [NUMBER_OF_SETS];
    logic [NODES-1:0]          upd_bits;
    logic [NODES-1:0]          look_bits;
    logic                      access_ok;
    logic [NUMBER_OF_WAYS-1:0] occupied;
    logic [NUMBER_OF_WAYS-1:0] walk_way;
    logic                      walk_none;

    logic                      victim_valid_q, victim_valid_d;
    logic [NUMBER_OF_WAYS-1:0] victim_way_q,   victim_way_d;
    logic [WAY_BITS-1:0]       victim_index_q, victim_index_d;
    logic                      victim_empty_q, victim_empty_d;
    logic                      victim_none_q,  victim_none_d;
    logic                      access_error_q, access_error_d;

    // Accepted access needs exactly one way bit set
    always_comb begin
        access_ok = access_valid && (access_way != '0) &&
                    ((access_way & (access_way - NUMBER_OF_WAYS'(1))) == '0);
    end

    // New bits for the accessed set: every node on the path points away
    always_comb begin
        logic [TREE-1:0]  hit;
        logic [NODES-1:0] cur;
        hit = '0;
        for (int i = 0; i < NUMBER_OF_WAYS; i++) hit[NODES+i] = access_way[i];
        for (int n = NODES - 1; n >= 0; n--)
            hit[n] = hit[left_child(n)] | hit[right_child(n)];
        cur      = plru_q[access_set];
        upd_bits = cur;
        for (int n = 0; n < NODES; n++)
            if (hit[n]) upd_bits[n] = hit[left_child(n)];
    end

    // State array next value; lookup forwards same-set update
    always_comb begin
        plru_d = plru_q;
        if (access_ok) plru_d[access_set] = upd_bits;
        look_bits = (access_ok && (access_set == lookup_set)) ? upd_bits
                                                              : plru_q[lookup_set];
    end

`ifdef PLRU_WAY_LOCK_EN
    assign occupied = ways_in_use | lock_mask;

    plru_tree_walk #(.NUMBER_OF_WAYS(NUMBER_OF_WAYS)) u_walk (
        .plru_bits   (look_bits),
        .lock_mask   (lock_mask),
        .victim_none (walk_none),
        .victim_way  (walk_way)
    );
`else
    assign occupied  = ways_in_use;
    assign walk_none = 1'b0;

    plru_tree_walk #(.NUMBER_OF_WAYS(NUMBER_OF_WAYS)) u_walk (
        .plru_bits  (look_bits),
        .victim_way (walk_way)
    );
`endif

    // Response next value: empty way wins, else PLRU; hold between strobes
    always_comb begin
        logic [NUMBER_OF_WAYS-1:0] empty_oh;
        empty_oh       = ~occupied & (occupied + NUMBER_OF_WAYS'(1));
        victim_valid_d = lookup_valid;
        victim_way_d   = victim_way_q;
        victim_index_d = victim_index_q;
        victim_empty_d = victim_empty_q;
        victim_none_d  = victim_none_q;
        access_error_d = access_error_q | (access_valid & ~access_ok);
        if (lookup_valid) begin
            if (empty_oh != '0) begin
                victim_way_d   = empty_oh;
                victim_empty_d = 1'b1;
                victim_none_d  = 1'b0;
            end else begin
                victim_way_d   = walk_way;
                victim_empty_d = 1'b0;
                victim_none_d  = walk_none;
            end
            victim_index_d = '0;
            for (int i = 0; i < NUMBER_OF_WAYS; i++)
                if (victim_way_d[i]) victim_index_d = victim_index_d | WAY_BITS'(i);
        end
    end

    // State and response registers, synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int s = 0; s < NUMBER_OF_SETS; s++) plru_q[s] <= '0;
            victim_valid_q <= 1'b0;
            victim_way_q   <= '0;
            victim_index_q <= '0;
            victim_empty_q <= 1'b0;
            victim_none_q  <= 1'b0;
            access_error_q <= 1'b0;
        end else begin
            plru_q         <= plru_d;
            victim_valid_q <= victim_valid_d;
            victim_way_q   <= victim_way_d;
            victim_index_q <= victim_index_d;
            victim_empty_q <= victim_empty_d;
            victim_none_q  <= victim_none_d;
            access_error_q <= access_error_d;
        end
    end

    assign victim_valid = victim_valid_q;
    assign victim_way   = victim_way_q;
    assign victim_index = victim_index_q;
    assign victim_empty = victim_empty_q;
    assign access_error = access_error_q;
`ifdef PLRU_WAY_LOCK_EN
    assign victim_none  = victim_none_q;
`else
    // Only meaningful with way locking
    logic unused_none;
    assign unused_none = victim_none_q;
`endif

endmodule

// File: tb/tb_plru_victim_select.sv
// Directed-vector bench for plru_victim_select (4 ways, 256 sets).
module tb_plru_victim_select;

    logic       clock;
    logic       reset;
    logic       lookup_valid;
    logic [7:0] lookup_set;
    logic [3:0] ways_in_use;
    logic       access_valid;
    logic [7:0] access_set;
    logic [3:0] access_way;
    logic       victim_valid;
    logic [3:0] victim_way;
    logic [1:0] victim_index;
    logic       victim_empty;
    logic       access_error;
`ifdef PLRU_WAY_LOCK_EN
    logic [3:0] lock_mask;
    logic       victim_none;
`endif

    int n_cmp = 0;
    int n_err = 0;

    plru_victim_select #(.NUMBER_OF_WAYS(4), .NUMBER_OF_SETS(256)) dut (
        .clock        (clock),
        .reset        (reset),
        .lookup_valid (lookup_valid),
        .lookup_set   (lookup_set),
        .ways_in_use  (ways_in_use),
        .access_valid (access_valid),
        .access_set   (access_set),
        .access_way   (access_way),
`ifdef PLRU_WAY_LOCK_EN
        .lock_mask    (lock_mask),
        .victim_none  (victim_none),
`endif
        .victim_valid (victim_valid),
        .victim_way   (victim_way),
        .victim_index (victim_index),
        .victim_empty (victim_empty),
        .access_error (access_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the capturing edge
    task automatic step(input logic lv, input logic [7:0] ls, input logic [3:0] wiu,
                        input logic av, input logic [7:0] as, input logic [3:0] aw);
        @(negedge clock);
        lookup_valid = lv;  lookup_set = ls;  ways_in_use = wiu;
        access_valid = av;  access_set = as;  access_way  = aw;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_vic(input string tag, input logic [3:0] way, input logic [1:0] idx,
                           input logic emp);
        chk({tag, ".valid"}, 32'(victim_valid), 32'd1);
        chk({tag, ".way"},   32'(victim_way),   32'(way));
        chk({tag, ".index"}, 32'(victim_index), 32'(idx));
        chk({tag, ".empty"}, 32'(victim_empty), 32'(emp));
    endtask

    task automatic lookup(input string tag, input logic [7:0] s, input logic [3:0] wiu,
                          input logic [3:0] way, input logic [1:0] idx, input logic emp);
        step(1'b1, s, wiu, 1'b0, 8'd0, 4'd0);
        chk_vic(tag, way, idx, emp);
    endtask

    task automatic access(input logic [7:0] s, input logic [3:0] aw);
        step(1'b0, 8'd0, 4'd0, 1'b1, s, aw);
    endtask

    initial begin
        reset = 1'b0;
        lookup_valid = 1'b0; lookup_set = '0; ways_in_use = '0;
        access_valid = 1'b0; access_set = '0; access_way  = '0;
`ifdef PLRU_WAY_LOCK_EN
        lock_mask = '0;
`endif
        step(1'b0, 8'd0, 4'd0, 1'b0, 8'd0, 4'd0);
        step(1'b0, 8'd0, 4'd0, 1'b0, 8'd0, 4'd0);
        chk("rst.valid", 32'(victim_valid), 32'd0);
        chk("rst.way",   32'(victim_way),   32'd0);
        chk("rst.index", 32'(victim_index), 32'd0);
        chk("rst.empty", 32'(victim_empty), 32'd0);
        chk("rst.err",   32'(access_error), 32'd0);
        reset = 1'b1;

        // Full set from reset: all bits 0 -> way 0
        lookup("init", 8'd0, 4'b1111, 4'b0001, 2'd0, 1'b0);
        // Idle: strobe drops, payload holds
        step(1'b0, 8'd0, 4'd0, 1'b0, 8'd0, 4'd0);
        chk("idle.valid", 32'(victim_valid), 32'd0);
        chk("idle.way",   32'(victim_way),   32'b0001);

        // Empty priority, back-to-back lookups
        lookup("emp1011", 8'd0, 4'b1011, 4'b0100, 2'd2, 1'b1);
        lookup("emp0000", 8'd0, 4'b0000, 4'b0001, 2'd0, 1'b1);
        lookup("emp0111", 8'd0, 4'b0111, 4'b1000, 2'd3, 1'b1);

        // PLRU sequence on set 5
        access(8'd5, 4'b0001);
        lookup("seq.w0", 8'd5, 4'b1111, 4'b0100, 2'd2, 1'b0);
        access(8'd5, 4'b0100);
        lookup("seq.w2", 8'd5, 4'b1111, 4'b0010, 2'd1, 1'b0);
        access(8'd5, 4'b0010);
        lookup("seq.w1", 8'd5, 4'b1111, 4'b1000, 2'd3, 1'b0);
        chk("seq.err", 32'(access_error), 32'd0);

        // Forwarding: same-cycle access and lookup on set 7
        step(1'b1, 8'd7, 4'b1111, 1'b1, 8'd7, 4'b0001);
        chk_vic("fwd.s7", 4'b0100, 2'd2, 1'b0);
        // Lookup on set 8 while set 9 is accessed: unaffected
        step(1'b1, 8'd8, 4'b1111, 1'b1, 8'd9, 4'b0001);
        chk_vic("fwd.s8", 4'b0001, 2'd0, 1'b0);
        lookup("fwd.s7st", 8'd7, 4'b1111, 4'b0100, 2'd2, 1'b0);

        // Non-one-hot access: error set, no state change, sticky
        access(8'd5, 4'b0011);
        chk("err.set", 32'(access_error), 32'd1);
        lookup("err.s5", 8'd5, 4'b1111, 4'b1000, 2'd3, 1'b0);
        access(8'd5, 4'b0000);
        step(1'b0, 8'd0, 4'd0, 1'b0, 8'd0, 4'd0);
        chk("err.stky", 32'(access_error), 32'd1);
        lookup("err.s5b", 8'd5, 4'b1111, 4'b1000, 2'd3, 1'b0);

        // Reset mid-stream with a lookup in flight
        @(negedge clock);
        reset = 1'b0;
        lookup_valid = 1'b1; lookup_set = 8'd5; ways_in_use = 4'b1111;
        access_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("mrst.valid", 32'(victim_valid), 32'd0);
        chk("mrst.way",   32'(victim_way),   32'd0);
        chk("mrst.index", 32'(victim_index), 32'd0);
        chk("mrst.err",   32'(access_error), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        lookup("mrst.s5", 8'd5, 4'b1111, 4'b0001, 2'd0, 1'b0);
        lookup("mrst.s7", 8'd7, 4'b1111, 4'b0001, 2'd0, 1'b0);

`ifdef PLRU_WAY_LOCK_EN
        lock_mask = 4'b0011;
        lookup("lk.full", 8'd20, 4'b1111, 4'b0100, 2'd2, 1'b0);
        chk("lk.none0", 32'(victim_none), 32'd0);
        lookup("lk.empty", 8'd20, 4'b0000, 4'b0100, 2'd2, 1'b1);
        lock_mask = 4'b1111;
        step(1'b1, 8'd20, 4'b1111, 1'b0, 8'd0, 4'd0);
        chk("lk.all.valid", 32'(victim_valid), 32'd1);
        chk("lk.all.way",   32'(victim_way),   32'd0);
        chk("lk.all.none",  32'(victim_none),  32'd1);
        lock_mask = 4'b0000;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
